alu_cmd_sequencer: RTL and testbench

Command front-end for the 16-bit ALU: accepts one opcode plus operand pair over a valid/ready handshake and decodes the opcode into a unit enable and `ALU_FUNC`. It then waits for the selected execution unit's result flag, captures the result, and presents it downstream over a second valid/ready handshake. It is the initiator for the registered arithmetic, logic, compare and shift units, which respond one cycle after enable with `<unit>_OUT` and `<unit>_Flag`.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_cmd_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit-select codes, compare function codes,
// opcode layout and the command sequencer state encoding.
package alu_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] CMP_NOP = 2'b00;
    localparam logic [1:0] CMP_EQ  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_LT  = 2'b11;

    // Opcode as carried on in_opcode: [3:2] unit, [1:0] function
    typedef struct packed {
        logic [1:0] unit;
        logic [1:0] func;
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: accepts one command, enables the selected unit for
// one cycle, waits for its flag, captures the result and hands it downstream.
// Optional macro ALU_SEQ_TIMEOUT_EN bounds the wait to TIMEOUT_CYCLES and
// completes with out_err=1 / out_result=0 when the unit never answers.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = 16,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_opcode,
    input  logic [IN_DATA_WIDTH-1:0]  in_a,
    input  logic [IN_DATA_WIDTH-1:0]  in_b,
    output logic [IN_DATA_WIDTH-1:0]  A,
    output logic [IN_DATA_WIDTH-1:0]  B,
    output logic [1:0]                ALU_FUNC,
    output logic                      ARITH_enable,
    output logic                      LOGIC_enable,
    output logic                      CMP_enable,
    output logic                      SHIFT_enable,
    input  logic [OUT_DATA_WIDTH-1:0] ARITH_OUT,
    input  logic [OUT_DATA_WIDTH-1:0] LOGIC_OUT,
    input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
    input  logic [OUT_DATA_WIDTH-1:0] SHIFT_OUT,
    input  logic                      ARITH_Flag,
    input  logic                      LOGIC_Flag,
    input  logic                      CMP_Flag,
    input  logic                      SHIFT_Flag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_DATA_WIDTH-1:0] out_result,
    output logic [1:0]                out_unit,
    output logic                      out_err
);

    seq_state_e                state_q, state_d;
    alu_op_t                   op_q;
    logic [IN_DATA_WIDTH-1:0]  a_q, b_q;
    logic [OUT_DATA_WIDTH-1:0] res_q;
    logic [1:0]                unit_q;
    logic                      load_cmd, cap_ok;
    logic                      sel_flag;
    logic [OUT_DATA_WIDTH-1:0] sel_out;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             cap_to, err_q;
    logic             expired;

    // Last permitted WAIT cycle is the one where the counter reads TIMEOUT_CYCLES-1
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign out_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign out_err        = 1'b0;
`endif

    // Gate in_ready with RST so it reads 0 for the whole reset window
    assign in_ready   = RST && (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign A          = a_q;
    assign B          = b_q;
    assign ALU_FUNC   = op_q.func;
    assign out_result = res_q;
    assign out_unit   = unit_q;

    // Route the registered unit's flag/result; other units' flags never reach the FSM
    always_comb begin
        sel_flag = ARITH_Flag;
        sel_out  = ARITH_OUT;
        case (op_q.unit)
            UNIT_LOGIC: begin sel_flag = LOGIC_Flag; sel_out = LOGIC_OUT; end
            UNIT_CMP:   begin sel_flag = CMP_Flag;   sel_out = CMP_OUT;   end
            UNIT_SHIFT: begin sel_flag = SHIFT_Flag; sel_out = SHIFT_OUT; end
            default:    ;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state, one-cycle unit enable in ISSUE, capture strobes
    always_comb begin
        state_d      = state_q;
        load_cmd     = 1'b0;
        cap_ok       = 1'b0;
        ARITH_enable = 1'b0;
        LOGIC_enable = 1'b0;
        CMP_enable   = 1'b0;
        SHIFT_enable = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        cap_to       = 1'b0;
`endif
        case (state_q)
            S_IDLE: if (in_valid) begin
                load_cmd = 1'b1;
                state_d  = S_ISSUE;
            end
            S_ISSUE: begin
                ARITH_enable = (op_q.unit == UNIT_ARITH);
                LOGIC_enable = (op_q.unit == UNIT_LOGIC);
                CMP_enable   = (op_q.unit == UNIT_CMP);
                SHIFT_enable = (op_q.unit == UNIT_SHIFT);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // A flag on the expiry cycle still counts as a normal completion
                if (sel_flag) begin
                    cap_ok  = 1'b1;
                    state_d = S_DONE;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (expired) begin
                    cap_to  = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Command and result registers; result fields hold through DONE
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            unit_q <= '0;
        end else begin
            if (load_cmd) begin
                op_q <= alu_op_t'(in_opcode);
                a_q  <= in_a;
                b_q  <= in_b;
            end
            if (cap_ok) begin
                res_q  <= sel_out;
                unit_q <= op_q.unit;
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            else if (cap_to) begin
                res_q  <= '0;
                unit_q <= op_q.unit;
            end
`endif
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    // Wait counter cleared while issuing, so WAIT starts at zero; error flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)     cnt_q <= '0;
            else if (state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
            if (cap_ok)      err_q <= 1'b0;
            else if (cap_to) err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural execution units with
// per-unit response delay, mute and flag injection; expected results come
// from the command itself.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [3:0]    in_opcode = '0;
    logic [W-1:0]  in_a = '0, in_b = '0, A, B;
    logic [1:0]    ALU_FUNC, out_unit;
    logic          ARITH_enable, LOGIC_enable, CMP_enable, SHIFT_enable;
    logic [W-1:0]  ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT, out_result;
    logic          ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag;
    logic          out_valid, out_ready = 1'b0, out_err;

    int n_chk = 0, n_err = 0, cyc = 0;
    int pulses [4] = '{0, 0, 0, 0};

    // Unit model controls
    logic [3:0]          mute = '0, inj = '0, flag_q = '0;
    int                  dly  [4] = '{0, 0, 0, 0};
    int                  pend [4] = '{0, 0, 0, 0};
    logic [3:0][W-1:0]   ures = '0;
    logic [3:0]          en_vec;

    always #5 CLK = ~CLK;

    alu_cmd_sequencer #(.IN_DATA_WIDTH(W), .OUT_DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b), .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
        .ARITH_enable(ARITH_enable), .LOGIC_enable(LOGIC_enable),
        .CMP_enable(CMP_enable), .SHIFT_enable(SHIFT_enable),
        .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .ARITH_Flag(ARITH_Flag), .LOGIC_Flag(LOGIC_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_unit(out_unit), .out_err(out_err)
    );

    assign en_vec = {SHIFT_enable, CMP_enable, LOGIC_enable, ARITH_enable};

    // What each execution unit computes for a given function and operands
    function automatic logic [W-1:0] unit_calc(input logic [1:0] u, input logic [1:0] f,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        case (u)
            UNIT_ARITH: case (f) 2'd0: return a + b; 2'd1: return a - b;
                                 2'd2: return W'(a * b); default: return a + 1'b1; endcase
            UNIT_LOGIC: case (f) 2'd0: return a & b; 2'd1: return a | b;
                                 2'd2: return a ^ b; default: return ~(a & b); endcase
            UNIT_CMP:   case (f) CMP_NOP: return '0;
                                 CMP_EQ:  return (a == b) ? W'(1) : '0;
                                 CMP_GT:  return (a > b)  ? W'(2) : '0;
                                 default: return (a < b)  ? W'(3) : '0; endcase
            default:    case (f) 2'd0: return a >> 1; 2'd1: return a << 1;
                                 2'd2: return b >> 1; default: return b << 1; endcase
        endcase
    endfunction

    // Registered units: flag one cycle after enable (plus dly), junk result otherwise
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            flag_q[i] <= 1'b0;
            if (en_vec[i] && !mute[i]) begin
                ures[i] <= unit_calc(2'(i), ALU_FUNC, A, B);
                if (dly[i] == 0) flag_q[i] <= 1'b1;
                else             pend[i]   <= dly[i];
            end else if (pend[i] > 0) begin
                pend[i] <= pend[i] - 1;
                if (pend[i] == 1) flag_q[i] <= 1'b1;
            end
        end
    end

    assign ARITH_Flag = flag_q[0] | inj[0];
    assign LOGIC_Flag = flag_q[1] | inj[1];
    assign CMP_Flag   = flag_q[2] | inj[2];
    assign SHIFT_Flag = flag_q[3] | inj[3];
    assign ARITH_OUT  = flag_q[0] ? ures[0] : 16'hDEA0;
    assign LOGIC_OUT  = flag_q[1] ? ures[1] : 16'hDEA1;
    assign CMP_OUT    = flag_q[2] ? ures[2] : 16'hDEA2;
    assign SHIFT_OUT  = flag_q[3] ? ures[3] : 16'hDEA3;

    // Count enable-high cycles per unit
    always @(negedge CLK) if (RST) for (int i = 0; i < 4; i++) pulses[i] <= pulses[i] + int'(en_vec[i]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Offer a command at a negedge; returns at the negedge of the ISSUE cycle
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
        @(negedge CLK);
        in_valid = 1'b0; in_opcode = 4'($urandom); in_a = W'($urandom); in_b = W'($urandom);
    endtask

    // Full transaction with per-cycle checks; starts and ends in IDLE at a negedge
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall);
        logic [W-1:0] exp;
        exp = unit_calc(op[3:2], op[1:0], a, b);
        chk("idle_in_ready", in_ready, 1);
        out_ready = 1'b0;
        issue(op, a, b);
        chk("issue_enables", en_vec, 4'b0001 << op[3:2]);
        chk("issue_A", A, a);
        chk("issue_B", B, b);
        chk("issue_func", ALU_FUNC, op[1:0]);
        chk("issue_in_ready", in_ready, 0);
        @(negedge CLK);
        chk("wait_enables", en_vec, 0);
        chk("wait_out_valid", out_valid, 0);
        @(negedge CLK);
        chk("done_out_valid", out_valid, 1);
        chk("done_result", out_result, exp);
        chk("done_unit", out_unit, op[3:2]);
        chk("done_err", out_err, 0);
        repeat (stall) begin
            @(negedge CLK);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_result", out_result, exp);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
    endtask

    initial begin
        int t0, seen;
        int p0 [4];
        logic [W-1:0] ra, rb;
        logic [3:0]   rop;

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_enables", en_vec, 0);
        chk("rst_result", out_result, 0);
        chk("rst_err", out_err, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // CMP EQ, equal operands; CMP LT with a 5-cycle downstream stall
        run_cmd(4'b1001, 16'h1234, 16'h1234, 0);
        run_cmd(4'b1011, 16'd3, 16'd7, 5);

        // Back-to-back, one per 4 cycles, each enable pulses once
        p0 = pulses;
        t0 = cyc;
        run_cmd(4'b0000, 16'h1111, 16'h2222, 0);
        run_cmd(4'b0110, 16'hF0F0, 16'h0FF0, 0);
        run_cmd(4'b1101, 16'h8001, 16'h0000, 0);
        run_cmd(4'b1010, 16'h0009, 16'h0002, 0);
        chk("b2b_cycles", 32'(cyc - t0), 32'd16);
        for (int i = 0; i < 4; i++) chk("b2b_pulses", 32'(pulses[i] - p0[i]), 32'd1);

        // Stray ARITH flag while a slow CMP is outstanding
        dly[2] = 2;
        issue(4'b1001, 16'h00AB, 16'h00AB);
        @(negedge CLK); inj[0] = 1'b1;
        @(negedge CLK); chk("stray_no_valid", out_valid, 0);
        @(negedge CLK); inj[0] = 1'b0; chk("stray_no_valid2", out_valid, 0);
        @(negedge CLK);
        chk("stray_valid", out_valid, 1);
        chk("stray_result", out_result, 16'h0001);
        chk("stray_unit", out_unit, UNIT_CMP);
        out_ready = 1'b1; @(negedge CLK); out_ready = 1'b0;
        dly[2] = 0;

        // Randomized commands and stalls
        for (int n = 0; n < 24; n++) begin
            rop = 4'($urandom);
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            run_cmd(rop, ra, rb, $urandom_range(0, 3));
        end

`ifdef ALU_SEQ_TIMEOUT_EN
        // Silent unit: error completion after TO wait cycles
        mute[2] = 1'b1;
        issue(4'b1001, 16'h5, 16'h5);
        repeat (TO) @(negedge CLK);
        chk("to_not_yet", out_valid, 0);
        @(negedge CLK);
        chk("to_valid", out_valid, 1);
        chk("to_err", out_err, 1);
        chk("to_result", out_result, 0);
        out_ready = 1'b1; @(negedge CLK); out_ready = 1'b0;
        // Flag on the expiry cycle wins
        mute[2] = 1'b0; dly[2] = TO - 1;
        issue(4'b1001, 16'h7, 16'h7);
        repeat (TO) @(negedge CLK);
        chk("edge_not_yet", out_valid, 0);
        @(negedge CLK);
        chk("edge_valid", out_valid, 1);
        chk("edge_err", out_err, 0);
        chk("edge_result", out_result, 16'h0001);
        out_ready = 1'b1; @(negedge CLK); out_ready = 1'b0;
        dly[2] = 0;
        mute[2] = 1'b1;
        issue(4'b1001, 16'h1, 16'h1);
        @(negedge CLK);
`else
        // Silent unit: stays in WAIT indefinitely
        mute[2] = 1'b1;
        issue(4'b1001, 16'h5, 16'h5);
        seen = 0;
        repeat (100) begin @(negedge CLK); seen += int'(out_valid); end
        chk("nto_no_valid", 32'(seen), 0);
        chk("nto_in_ready", in_ready, 0);
`endif

        // Reset during WAIT, then a late flag must be ignored
        RST = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out", {out_valid, out_err, out_unit, out_result}, 0);
        chk("midrst_drive", {en_vec, ALU_FUNC, A, B}, 0);
        @(negedge CLK);
        RST = 1'b1; mute[2] = 1'b0;
        @(negedge CLK);
        chk("midrst_idle", in_ready, 1);
        inj[2] = 1'b1;
        @(negedge CLK);
        inj[2] = 1'b0;
        seen = 0;
        repeat (3) begin @(negedge CLK); seen += int'(out_valid); end
        chk("late_flag_ignored", 32'(seen), 0);
        chk("late_flag_in_ready", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
